// File: rtl/buffer_pkg.sv
// Shared definitions for the byte-to-word buffer fill path.
// The target buffer and its writer both import these.
package buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADR_W          = 8;
  localparam int SIZE_DEFAULT   = 64;

endpackage

// File: rtl/buffer_writer_if.sv
// Control, byte-stream and buffer-write signals of buffer_writer.
// Byte handshake: a byte (with in_last) transfers on a rising clk edge where in_valid && in_ready.
interface buffer_writer_if;
  logic        start;
  logic [7:0]  start_adr;
  logic [7:0]  len_words;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wr_en;
  logic [7:0]  wr_adr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [7:0]  words_written;
  logic [1:0]  state;

  modport slave (
    input  start, start_adr, len_words, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_adr, wr_data, busy, done, words_written, state
  );

  modport master (
    output start, start_adr, len_words, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_adr, wr_data, busy, done, words_written, state
  );
endinterface

// File: rtl/buffer_writer.sv
// Packs an incoming byte stream big-endian into 32-bit words and writes them
// to a circular buffer of SIZE bytes starting at a word-aligned address.
module buffer_writer
  import buffer_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  buffer_writer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FILL = FILL;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [ADR_W-1:0] ADR_MASK = ADR_W'(SIZE - 1);
  localparam logic [ADR_W-1:0] WORD_STEP = ADR_W'(BYTES_PER_WORD);

  logic [1:0]       state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [31:0]      pack_q, pack_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             done_q, done_d;

  logic        hs;
  logic [31:0] pack_base;
  logic [31:0] lane_val;
  logic [31:0] pack_next;
  logic [1:0]  lane_inv;

  assign hs        = (state_q == S_FILL) && bus.in_valid;
  assign lane_inv  = 2'd3 - k_q;
  // Lane 0 starts a fresh word, so lanes not yet filled always read as 0x00.
  assign pack_base = (k_q == 2'd0) ? 32'h0 : pack_q;
  assign lane_val  = {24'h0, bus.in_data} << {lane_inv, 3'b000};
  assign pack_next = pack_base | lane_val;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pack_d    = pack_q;
    adr_d     = adr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = 8'd0;
          if (bus.len_words != 8'd0) begin
            adr_d   = {bus.start_adr[7:2], 2'b00} & ADR_MASK;
            len_d   = bus.len_words;
            k_d     = 2'd0;
            pack_d  = 32'h0;
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (hs) begin
          pack_d = pack_next;
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3 || bus.in_last) begin
            wr_en_d   = 1'b1;
            wr_adr_d  = adr_q;
            wr_data_d = pack_next;
            adr_d     = (adr_q + WORD_STEP) & ADR_MASK;
            cnt_d     = cnt_q + 8'd1;
            k_d       = 2'd0;
            // Final write lands in the DONE cycle together with the done pulse.
            if ((cnt_q + 8'd1 == len_q) || bus.in_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= 2'd0;
      pack_q    <= 32'h0;
      adr_q     <= '0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pack_q    <= pack_d;
      adr_q     <= adr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready      = (state_q == S_FILL);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_adr        = wr_adr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.done          = done_q;
  assign bus.words_written = cnt_q;
  assign bus.state         = state_q;

endmodule

// File: doc/buffer_writer.md
BUFFER_WRITER -- requirements
Module: buffer_writer

Interface
REQ-001 The block SHALL have parameter SIZE, default 64, giving the target buffer depth in bytes; it SHALL be a power of two, at least 4 and at most 256.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a fill.
REQ-006 start_adr  in  8  first byte address of the fill; bits [1:0] SHALL be ignored (treated as 0).
REQ-007 len_words  in  8  number of 32-bit words to write; valid range 0..SIZE/4.
REQ-008 in_valid  in  1  input byte valid.
REQ-009 in_ready  out  1  block accepts an input byte.
REQ-010 in_data  in  8  input byte.
REQ-011 in_last  in  1  marks the final byte of the stream; qualified by the handshake.
REQ-012 wr_en  out  1  buffer write strobe.
REQ-013 wr_adr  out  8  buffer byte address, always 4-aligned.
REQ-014 wr_data  out  32  packed word; the first byte received SHALL occupy [31:24].
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 words_written  out  8  words written in the current or last fill; held until the next start.

Function
REQ-018 A byte SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-019 The block SHALL implement the states IDLE, FILL and DONE.
REQ-020 IDLE, start=1, len_words>0: the block SHALL latch {start_adr[7:2],2'b00} and len_words, clear words_written and the byte index k, and go to FILL.
REQ-021 IDLE, start=1, len_words=0: the block SHALL go to DONE with no write.
REQ-022 in_ready SHALL equal (state==FILL); it SHALL be purely state-decoded with no combinational path from in_valid.
REQ-023 An accepted byte SHALL be stored at bits [31-8k:24-8k] of the pack register, and k SHALL then increment modulo 4.
REQ-024 When the byte with k==3 is accepted, or any byte with in_last=1 is accepted, the block SHALL register wr_en=1 for the next cycle only.
REQ-025 On that write cycle, wr_data SHALL be the pack register with unfilled lanes forced to 0x00, and wr_adr SHALL be the current address.
REQ-026 After each write, the address SHALL advance by 4 modulo SIZE, and words_written SHALL increment.
REQ-027 Write latency SHALL be exactly 1 cycle from the completing handshake to wr_en.
REQ-028 Back-to-back words SHALL be supported at one byte per cycle with no stall.
REQ-029 The block SHALL go from FILL to DONE in the cycle of the handshake that completes word len_words, or of any in_last handshake.
REQ-030 That final write SHALL coincide with the DONE cycle, so no further byte is accepted.
REQ-031 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-032 start SHALL be ignored outside IDLE.
REQ-033 in_last SHALL be ignored in IDLE and DONE.
REQ-034 in_valid with in_ready=0 SHALL have no effect.
REQ-035 wr_en SHALL never be asserted outside a write cycle defined above.

Reset
REQ-036 With rst_n=0 at a clock edge, the state SHALL be IDLE and outputs SHALL be in_ready=0, wr_en=0, wr_adr=0, wr_data=0, busy=0, done=0, words_written=0.
REQ-037 Reset SHALL also clear k, the pack register, the latched length and the latched address.
REQ-038 On reset mid-fill, the partial word SHALL be discarded and no write SHALL follow; reset SHALL take priority over every other input.

Structure
REQ-039 The shared package buffer_pkg SHALL hold the state enum (IDLE, FILL, DONE), BYTES_PER_WORD=4, ADR_W=8 and the SIZE default; the buffer and this block SHALL both import it.
REQ-040 The block SHALL be a single module with no sub-module; the packer SHALL be an inline register and lane index.
REQ-041 All outputs SHALL be registered, except in_ready and busy, which SHALL be state-decoded.

Verification
REQ-042 Scenario 1: start_adr=0, len=2, bytes 11..18 back-to-back -> writes (0,0x11121314) and (4,0x15161718); done on the second write; words_written=2.
REQ-043 Scenario 2: SIZE=64, start_adr=60, len=2 -> write addresses 60 then 0 (wrap); start_adr=0x3D -> first address 60.
REQ-044 Scenario 3: len=4, bytes AA, BB with in_last on BB -> one write 0xAABB0000; done; words_written=1; in_ready low afterwards.
REQ-045 Scenario 4: len=2 with in_valid toggling randomly, plus start pulsed during FILL -> same writes as Scenario 1; the extra start is ignored.
REQ-046 Scenario 5: rst_n low after 3 accepted bytes -> no wr_en; all outputs at reset values; the next start behaves freshly.
REQ-047 Scenario 6: start with len=0 -> done on the next cycle; no wr_en; words_written=0.
